// File: rtl/vector_issue_queue_pkg.sv
// Shared constants and helpers for the vector issue queue: register-vector field
// layout, scoreboard sizing and default bundle field widths.
package vector_issue_queue_pkg;

    localparam int VD_LSB  = 0;
    localparam int VS1_LSB = 5;
    localparam int VS2_LSB = 10;
    localparam int VD_EN   = 15;
    localparam int VS1_EN  = 16;
    localparam int VS2_EN  = 17;

    localparam int VREG_COUNT = 32;
    localparam int VREG_W     = 5;

    localparam int SYSTEM_VECTOR_LENGTH_DEF    = 8;
    localparam int RESOURCE_VECTOR_LENGTH_DEF  = 6;
    localparam int REGISTER_VECTOR_LENGTH_DEF  = 24;
    localparam int OPERATION_VECTOR_LENGTH_DEF = 16;

    typedef logic [VREG_W-1:0] vreg_t;

    typedef struct packed {
        vreg_t vd;
        vreg_t vs1;
        vreg_t vs2;
        logic  vd_en;
        logic  vs1_en;
        logic  vs2_en;
    } reg_fields_t;

    // Only the low 18 bits carry operand information; anything above rides along.
    function automatic reg_fields_t decode_reg(input logic [17:0] r);
        reg_fields_t f;
        f.vd     = r[VD_LSB  +: VREG_W];
        f.vs1    = r[VS1_LSB +: VREG_W];
        f.vs2    = r[VS2_LSB +: VREG_W];
        f.vd_en  = r[VD_EN];
        f.vs1_en = r[VS1_EN];
        f.vs2_en = r[VS2_EN];
        return f;
    endfunction

endpackage

// File: rtl/vector_issue_queue_if.sv
// Decode-side, back-end-side and writeback signals of the vector issue queue.
// slave = the queue itself, master = the surrounding pipeline.
interface vector_issue_queue_if
    import vector_issue_queue_pkg::*;
#(
    parameter int SYSTEM_VECTOR_LENGTH    = SYSTEM_VECTOR_LENGTH_DEF,
    parameter int RESOURCE_VECTOR_LENGTH  = RESOURCE_VECTOR_LENGTH_DEF,
    parameter int REGISTER_VECTOR_LENGTH  = REGISTER_VECTOR_LENGTH_DEF,
    parameter int OPERATION_VECTOR_LENGTH = OPERATION_VECTOR_LENGTH_DEF,
    parameter int DEPTH                   = 4,
    parameter int PTR_W                   = $clog2(DEPTH)
);
    logic                               flush_i;
    logic                               in_valid_i;
    logic                               in_ready_o;
    logic [SYSTEM_VECTOR_LENGTH-1:0]    in_system_i;
    logic [RESOURCE_VECTOR_LENGTH-1:0]  in_resource_i;
    logic [REGISTER_VECTOR_LENGTH-1:0]  in_register_i;
    logic [OPERATION_VECTOR_LENGTH-1:0] in_operation_i;
    logic                               out_valid_o;
    logic                               out_ready_i;
    logic [SYSTEM_VECTOR_LENGTH-1:0]    out_system_o;
    logic [RESOURCE_VECTOR_LENGTH-1:0]  out_resource_o;
    logic [REGISTER_VECTOR_LENGTH-1:0]  out_register_o;
    logic [OPERATION_VECTOR_LENGTH-1:0] out_operation_o;
    logic                               wb_valid_i;
    vreg_t                              wb_vreg_i;
    logic [PTR_W:0]                     occupancy_o;

    modport slave (
        input  flush_i, in_valid_i, in_system_i, in_resource_i, in_register_i,
               in_operation_i, out_ready_i, wb_valid_i, wb_vreg_i,
        output in_ready_o, out_valid_o, out_system_o, out_resource_o,
               out_register_o, out_operation_o, occupancy_o
    );

    modport master (
        output flush_i, in_valid_i, in_system_i, in_resource_i, in_register_i,
               in_operation_i, out_ready_i, wb_valid_i, wb_vreg_i,
        input  in_ready_o, out_valid_o, out_system_o, out_resource_o,
               out_register_o, out_operation_o, occupancy_o
    );
endinterface

// File: rtl/vector_issue_queue_scoreboard.sv
// Busy bit per vector register with three lookup ports. An issue setting a
// register outranks a writeback clearing the same register in the same cycle.
module vector_scoreboard
    import vector_issue_queue_pkg::*;
(
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            set_en,
    input  vreg_t           set_vreg,
    input  logic            clr_en,
    input  vreg_t           clr_vreg,
    input  vreg_t [2:0]     rd_vreg,
    output logic  [2:0]     rd_busy
);
    logic [VREG_COUNT-1:0] busy_reg;

    generate
        for (genvar gi = 0; gi < VREG_COUNT; gi++) begin : g_bit
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    busy_reg[gi] <= 1'b0;
                end else if (set_en && set_vreg == vreg_t'(gi)) begin
                    busy_reg[gi] <= 1'b1;
                end else if (clr_en && clr_vreg == vreg_t'(gi)) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end

        for (genvar gi = 0; gi < 3; gi++) begin : g_rd
            assign rd_busy[gi] = busy_reg[rd_vreg[gi]];
        end
    endgenerate
endmodule

// File: rtl/vector_issue_queue.sv
// In-order FIFO of decoded vector bundles; the head issues only when none of its
// enabled operands or its destination is marked busy in the scoreboard.
module vector_issue_queue
    import vector_issue_queue_pkg::*;
#(
    parameter int SYSTEM_VECTOR_LENGTH    = SYSTEM_VECTOR_LENGTH_DEF,
    parameter int RESOURCE_VECTOR_LENGTH  = RESOURCE_VECTOR_LENGTH_DEF,
    parameter int REGISTER_VECTOR_LENGTH  = REGISTER_VECTOR_LENGTH_DEF,
    parameter int OPERATION_VECTOR_LENGTH = OPERATION_VECTOR_LENGTH_DEF,
    parameter int DEPTH                   = 4,
    parameter int PTR_W                   = $clog2(DEPTH)
)(
    input  logic                clk_i,
    input  logic                rstn_i,
    vector_issue_queue_if.slave bus
);
    localparam int S_W = SYSTEM_VECTOR_LENGTH;
    localparam int R_W = RESOURCE_VECTOR_LENGTH;
    localparam int G_W = REGISTER_VECTOR_LENGTH;
    localparam int O_W = OPERATION_VECTOR_LENGTH;
    localparam int BUNDLE_W = S_W + R_W + G_W + O_W;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [BUNDLE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [PTR_W:0]      count_reg;

    logic                full;
    logic                empty;
    logic                enq;
    logic                iss;
    logic                hazard;
    logic                out_valid;
    logic [BUNDLE_W-1:0] head;
    logic [G_W-1:0]      head_register;
    reg_fields_t         head_fields;
    vreg_t [2:0]         sb_rd_vreg;
    logic  [2:0]         sb_rd_busy;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);

    // Show-ahead: the head entry is exposed combinationally.
    assign head          = mem[rd_ptr_reg];
    assign head_register = head[O_W +: G_W];
    assign head_fields   = decode_reg(head_register[17:0]);

    assign sb_rd_vreg = {head_fields.vd, head_fields.vs2, head_fields.vs1};

    vector_scoreboard u_sb (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .set_en   (iss && head_fields.vd_en),
        .set_vreg (head_fields.vd),
        .clr_en   (bus.wb_valid_i),
        .clr_vreg (bus.wb_vreg_i),
        .rd_vreg  (sb_rd_vreg),
        .rd_busy  (sb_rd_busy)
    );

    assign hazard = (head_fields.vs1_en && sb_rd_busy[0]) ||
                    (head_fields.vs2_en && sb_rd_busy[1]) ||
                    (head_fields.vd_en  && sb_rd_busy[2]);

    assign out_valid = !empty && !hazard;
    // Flush discards any handshake in its cycle, including the scoreboard set.
    assign enq = bus.in_valid_i && !full && !bus.flush_i;
    assign iss = out_valid && bus.out_ready_i && !bus.flush_i;

    assign bus.in_ready_o      = !full;
    assign bus.out_valid_o     = out_valid;
    assign bus.occupancy_o     = count_reg;
    assign bus.out_system_o    = head[O_W + G_W + R_W +: S_W];
    assign bus.out_resource_o  = head[O_W + G_W +: R_W];
    assign bus.out_register_o  = head_register;
    assign bus.out_operation_o = head[0 +: O_W];

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr_reg] <= {bus.in_system_i, bus.in_resource_i,
                                bus.in_register_i, bus.in_operation_i};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (iss) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({enq, iss})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_issue_queue.sv
// Directed bench for vector_issue_queue: reset, RAW stall, fill/wrap, set-vs-clear
// priority, streaming at constant occupancy, flush and asynchronous reset.
module tb_vector_issue_queue;
    import vector_issue_queue_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clk = ~clk;

    vector_issue_queue_if #(.DEPTH(4)) bus ();

    vector_issue_queue #(.DEPTH(4)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    function automatic logic [23:0] mkreg(input int vd, input int vs1, input int vs2,
                                          input bit vd_en, input bit vs1_en, input bit vs2_en);
        return {6'h2A, vs2_en, vs1_en, vd_en, 5'(vs2), 5'(vs1), 5'(vd)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [7:0] sys, input logic [23:0] rg,
                       input logic [15:0] op);
        bus.in_valid_i     = v;
        bus.in_system_i    = sys;
        bus.in_resource_i  = 6'(op);
        bus.in_register_i  = rg;
        bus.in_operation_i = op;
    endtask

    initial begin
        bus.flush_i = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.wb_valid_i = 1'b0;
        bus.wb_vreg_i = '0;
        put(1'b0, 8'h00, 24'h0, 16'h0);

        // Reset
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        chk("reset_in_ready", 32'(bus.in_ready_o), 1);
        chk("reset_out_valid", 32'(bus.out_valid_o), 0);
        chk("reset_occupancy", 32'(bus.occupancy_o), 0);

        // Single bundle with vd=3: visible one cycle after enqueue, then issued
        bus.out_ready_i = 1'b1;
        put(1'b1, 8'h11, mkreg(3, 0, 0, 1, 0, 0), 16'hA001);
        #1 chk("t1_no_bypass", 32'(bus.out_valid_o), 0);
        tick();
        put(1'b0, 8'h00, 24'h0, 16'h0);
        #1;
        chk("t1_valid", 32'(bus.out_valid_o), 1);
        chk("t1_register", 32'(bus.out_register_o), 32'(mkreg(3, 0, 0, 1, 0, 0)));
        chk("t1_system", 32'(bus.out_system_o), 32'h11);
        chk("t1_resource", 32'(bus.out_resource_o), 32'h01);
        chk("t1_occupancy", 32'(bus.occupancy_o), 1);
        tick();
        #1;
        chk("t1_drained_occ", 32'(bus.occupancy_o), 0);
        chk("t1_drained_valid", 32'(bus.out_valid_o), 0);

        // RAW on v3 until writeback
        put(1'b1, 8'h22, mkreg(4, 3, 0, 0, 1, 0), 16'hB002);
        tick();
        put(1'b0, 8'h00, 24'h0, 16'h0);
        #1;
        chk("t2_stall", 32'(bus.out_valid_o), 0);
        chk("t2_stall_occ", 32'(bus.occupancy_o), 1);
        tick();
        #1 chk("t2_stall2", 32'(bus.out_valid_o), 0);
        bus.wb_valid_i = 1'b1;
        bus.wb_vreg_i  = 5'd3;
        #1 chk("t2_wb_no_bypass", 32'(bus.out_valid_o), 0);
        tick();
        bus.wb_valid_i = 1'b0;
        #1;
        chk("t2_unblock", 32'(bus.out_valid_o), 1);
        chk("t2_op", 32'(bus.out_operation_o), 32'hB002);
        tick();
        #1 chk("t2_occ", 32'(bus.occupancy_o), 0);

        // Fill to full (pointers start at 2 so they wrap), reject a fifth
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 8'(8'h30 + i), mkreg(0, 0, 0, 0, 0, 0), 16'(16'hC000 + i));
            tick();
        end
        #1;
        chk("t3_full_ready", 32'(bus.in_ready_o), 0);
        chk("t3_full_occ", 32'(bus.occupancy_o), 4);
        put(1'b1, 8'h3F, mkreg(0, 0, 0, 0, 0, 0), 16'hCFFF);
        tick();
        put(1'b0, 8'h00, 24'h0, 16'h0);
        #1;
        chk("t3_fifth_occ", 32'(bus.occupancy_o), 4);
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_order%0d", i), 32'(bus.out_operation_o), 32'(16'hC000 + i));
            chk($sformatf("t3_occ%0d", i), 32'(bus.occupancy_o), 32'(4 - i));
            tick();
            #1;
        end
        chk("t3_empty_occ", 32'(bus.occupancy_o), 0);
        chk("t3_empty_valid", 32'(bus.out_valid_o), 0);
        chk("t3_empty_ready", 32'(bus.in_ready_o), 1);

        // Issue vd=7 while v7 writes back: set wins, next head reading vs2=7 stalls
        bus.out_ready_i = 1'b0;
        put(1'b1, 8'h40, mkreg(7, 0, 0, 1, 0, 0), 16'hD007);
        tick();
        put(1'b1, 8'h41, mkreg(8, 0, 7, 0, 0, 1), 16'hE007);
        tick();
        put(1'b0, 8'h00, 24'h0, 16'h0);
        bus.out_ready_i = 1'b1;
        bus.wb_valid_i  = 1'b1;
        bus.wb_vreg_i   = 5'd7;
        #1;
        chk("t4_head_valid", 32'(bus.out_valid_o), 1);
        chk("t4_head_op", 32'(bus.out_operation_o), 32'hD007);
        tick();
        bus.wb_valid_i = 1'b0;
        #1;
        chk("t4_set_wins", 32'(bus.out_valid_o), 0);
        chk("t4_next_head", 32'(bus.out_operation_o), 32'hE007);
        tick();
        #1 chk("t4_still_stalled", 32'(bus.out_valid_o), 0);
        bus.wb_valid_i = 1'b1;
        bus.wb_vreg_i  = 5'd7;
        tick();
        bus.wb_valid_i = 1'b0;
        #1 chk("t4_release", 32'(bus.out_valid_o), 1);
        tick();
        #1 chk("t4_occ", 32'(bus.occupancy_o), 0);

        // Stream at occupancy 2: enqueue and issue every cycle
        bus.out_ready_i = 1'b0;
        put(1'b1, 8'h50, mkreg(0, 0, 0, 0, 0, 0), 16'hF100);
        tick();
        put(1'b1, 8'h51, mkreg(0, 0, 0, 0, 0, 0), 16'hF101);
        tick();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            put(1'b1, 8'(8'h52 + i), mkreg(0, 0, 0, 0, 0, 0), 16'(16'hF102 + i));
            #1;
            chk($sformatf("t5_order%0d", i), 32'(bus.out_operation_o), 32'(16'hF100 + i));
            chk($sformatf("t5_occ%0d", i), 32'(bus.occupancy_o), 2);
            tick();
        end
        put(1'b0, 8'h00, 24'h0, 16'h0);
        #1;
        chk("t5_tail0", 32'(bus.out_operation_o), 32'hF10A);
        tick();
        #1 chk("t5_tail1", 32'(bus.out_operation_o), 32'hF10B);
        tick();
        #1 chk("t5_occ_end", 32'(bus.occupancy_o), 0);

        // Flush: make v9 busy, queue three (head writes v10), flush with a new enqueue
        put(1'b1, 8'h60, mkreg(9, 0, 0, 1, 0, 0), 16'h5009);
        tick();
        put(1'b0, 8'h00, 24'h0, 16'h0);
        #1 chk("t6_g_valid", 32'(bus.out_valid_o), 1);
        tick();
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, 8'(8'h61 + i), mkreg(10, 0, 0, (i == 0), 0, 0), 16'(16'h6000 + i));
            tick();
        end
        put(1'b0, 8'h00, 24'h0, 16'h0);
        #1;
        chk("t6_occ3", 32'(bus.occupancy_o), 3);
        chk("t6_head_valid", 32'(bus.out_valid_o), 1);
        bus.flush_i = 1'b1;
        bus.out_ready_i = 1'b1;
        put(1'b1, 8'h6F, mkreg(0, 0, 0, 0, 0, 0), 16'h6FFF);
        tick();
        bus.flush_i = 1'b0;
        bus.out_ready_i = 1'b0;
        put(1'b0, 8'h00, 24'h0, 16'h0);
        #1;
        chk("t6_flush_occ", 32'(bus.occupancy_o), 0);
        chk("t6_flush_valid", 32'(bus.out_valid_o), 0);
        chk("t6_flush_ready", 32'(bus.in_ready_o), 1);
        // v10 must not have been marked busy by the discarded issue
        put(1'b1, 8'h70, mkreg(0, 10, 0, 0, 1, 0), 16'h7000);
        tick();
        put(1'b0, 8'h00, 24'h0, 16'h0);
        #1;
        chk("t6_no_flush_issue", 32'(bus.out_valid_o), 1);
        chk("t6_l_op", 32'(bus.out_operation_o), 32'h7000);
        chk("t6_l_occ", 32'(bus.occupancy_o), 1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        #1 chk("t6_flush2_occ", 32'(bus.occupancy_o), 0);
        // v9 stays busy across the flush
        bus.out_ready_i = 1'b1;
        put(1'b1, 8'h80, mkreg(0, 9, 0, 0, 1, 0), 16'h8000);
        tick();
        put(1'b0, 8'h00, 24'h0, 16'h0);
        #1;
        chk("t6_sb_retained", 32'(bus.out_valid_o), 0);
        chk("t6_k_occ", 32'(bus.occupancy_o), 1);

        // Asynchronous reset mid-stream
        put(1'b1, 8'h81, mkreg(0, 0, 0, 0, 0, 0), 16'h8001);
        tick();
        put(1'b0, 8'h00, 24'h0, 16'h0);
        #1 chk("t7_pre_occ", 32'(bus.occupancy_o), 2);
        #2 rstn = 1'b0;
        #1;
        chk("t7_async_occ", 32'(bus.occupancy_o), 0);
        chk("t7_async_ready", 32'(bus.in_ready_o), 1);
        chk("t7_async_valid", 32'(bus.out_valid_o), 0);
        tick();
        tick();
        rstn = 1'b1;
        bus.out_ready_i = 1'b0;
        put(1'b1, 8'h90, mkreg(0, 9, 0, 0, 1, 0), 16'h9000);
        tick();
        put(1'b0, 8'h00, 24'h0, 16'h0);
        #1;
        chk("t7_sb_cleared", 32'(bus.out_valid_o), 1);
        chk("t7_op", 32'(bus.out_operation_o), 32'h9000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/vector_issue_queue.md
Name: vector_issue_queue

Overview:
- Consumes the decoded bundles that the vector decode stage produces (system, resource, register and operation vectors) and buffers them in an in-order FIFO.
- Tracks busy destination vector registers in a 32-entry scoreboard.
- Issues the head bundle to the vector execution back-end only when it is free of RAW/WAW hazards.
- Sits between vector decode and the vector lanes; writeback from the lanes clears scoreboard entries.

Parameters:
- SYSTEM_VECTOR_LENGTH, `system_vector_length, width of the system vector field
- RESOURCE_VECTOR_LENGTH, `resource_vector_length, width of the resource vector field
- REGISTER_VECTOR_LENGTH, `register_vector_length, width of the register vector field; must be >= 18
- OPERATION_VECTOR_LENGTH, `operation_vector_length, width of the operation vector field
- DEPTH, 4, FIFO entries; power of two, >= 2
- PTR_W, $clog2(DEPTH), pointer width

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  drop all queued bundles; scoreboard untouched
- in_valid_i  in  1  decoded bundle valid
- in_ready_o  out  1  queue can accept a bundle
- in_system_i  in  SYSTEM_VECTOR_LENGTH  decoded system vector
- in_resource_i  in  RESOURCE_VECTOR_LENGTH  decoded resource vector
- in_register_i  in  REGISTER_VECTOR_LENGTH  decoded register vector
- in_operation_i  in  OPERATION_VECTOR_LENGTH  decoded operation vector
- out_valid_o  out  1  head bundle issuable
- out_ready_i  in  1  back-end accepts bundle
- out_system_o, out_resource_o, out_register_o, out_operation_o  out  same widths  head bundle fields
- wb_valid_i  in  1  lane writeback done
- wb_vreg_i  in  5  vector register written back
- occupancy_o  out  PTR_W+1  number of queued bundles

Behaviour:
- Register vector layout, fixed: [4:0] vd, [9:5] vs1, [14:10] vs2, [15] vd_en, [16] vs1_en, [17] vs2_en. Upper bits are passed through untouched.
- Reset: FIFO empty, both pointers 0, scoreboard all 0, occupancy_o=0, in_ready_o=1, out_valid_o=0.
- Enqueue: in_valid_i & in_ready_o. in_ready_o = !full, with no same-cycle bypass through a full queue. Data is registered into the tail entry.
- Show-ahead head: the out_*_o fields are combinational from the head entry. A bundle enqueued in cycle N is visible and issuable at the earliest in cycle N+1.
- Hazard, evaluated on the registered scoreboard (sb):
  - hazard = (vs1_en & sb[vs1]) | (vs2_en & sb[vs2]) | (vd_en & sb[vd])
  - out_valid_o = !empty & !hazard
  - There is no writeback bypass: a register cleared in cycle N unblocks the head in cycle N+1.
- Issue: out_valid_o & out_ready_i. This pops the head and, if vd_en, sets sb[vd] at the next edge.
- Writeback: wb_valid_i clears sb[wb_vreg_i] at the next edge.
  - If issue sets and writeback clears the same register in the same cycle, set wins (the new producer is outstanding).
  - A writeback to a non-busy register is harmless.
- Simultaneous enqueue and issue: allowed whenever not full. Occupancy is unchanged and pointers advance independently. Pointers wrap modulo DEPTH. Full/empty is distinguished by the count register.
- flush_i:
  - Highest priority. Next cycle the queue is empty with pointers and count at 0.
  - An enqueue or issue in the same cycle is discarded; no scoreboard set from an issue in the flush cycle.
  - Scoreboard clears still apply.
- out_valid_o must not depend combinationally on out_ready_i.
- Reset mid-operation: asynchronous return to the reset state on the rstn_i falling edge. Queued bundles are lost.

Decomposition:
- Shared package/include (`riscv_vector.vh`): the register-vector field offsets (VD_LSB=0, VS1_LSB=5, VS2_LSB=10, VD_EN=15, VS1_EN=16, VS2_EN=17), VREG_COUNT=32, VREG_W=5.
- One natural sub-module: vector_scoreboard, which holds the 32-bit busy register, the set/clear priority and the three read ports.
- The FIFO stays inline.

Test Plan:
- Reset then idle → in_ready_o=1, out_valid_o=0, occupancy_o=0. Enqueue one bundle with vd=3, vd_en=1 and hold out_ready_i=1 → out_valid_o=1 the next cycle, then sb[3]=1.
- RAW stall: issue vd=3; then enqueue vs1=3, vs1_en=1 → out_valid_o=0 until wb_valid_i with wb_vreg_i=3. out_valid_o=1 exactly one cycle after the writeback edge.
- Fill with 4 bundles while out_ready_i=0 → in_ready_o=0, occupancy_o=4. A fifth in_valid_i is not accepted. Raise out_ready_i → entries issue in order, pointers wrap, occupancy_o counts down to 0.
- Same cycle: issue head vd=7 while wb_vreg_i=7 → sb[7]=1 afterwards. The next head reading vs2=7 stalls.
- Concurrent enqueue and issue at occupancy 2 for 10 cycles → occupancy_o stays 2 and output order matches input order.
- flush_i with 3 queued and a simultaneous in_valid_i → occupancy_o=0 next cycle, no issue occurs, and busy scoreboard bits are retained. Asserting rstn_i low mid-stream → all outputs return to reset values immediately.
